// File: rtl/tt_um_emern_spi_phy.sv
// SPI mode-0 target PHY: synchronizes the raw pins into the clk domain, shifts
// bytes in and out MSB first, and reports byte, frame and abort events.
module tt_um_emern_spi_phy #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_in,
    input  logic       sck_in,
    input  logic       mosi_in,
    output logic       miso_out,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       frame_active,
    output logic       frame_abort
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
    logic cs_s, sck_s, mosi_s;
    logic cs_d, sck_d;
    logic cs_fall, cs_rise, sck_rise, sck_fall;
    logic rst_seen, armed;

    state_t     state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic       first_byte, first_nxt;
    logic       byte_done, byte_done_nxt;
    logic [6:0] rx_shift, rx_shift_nxt;
    logic [7:0] tx_shift, tx_shift_nxt;
    logic [7:0] rx_data_nxt;
    logic       rx_valid_nxt, rx_first_nxt, tx_req_nxt, abort_nxt, miso_nxt;

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign cs_fall  = cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign sck_rise = ~sck_d & sck_s;
    assign sck_fall = sck_d & ~sck_s;

    assign frame_active = (state == ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_d      <= 1'b1;
            sck_d     <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_in};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
            cs_d      <= cs_s;
            sck_d     <= sck_s;
        end
    end

    // A frame may only start after CS has been seen high at the pin since
    // reset, so a CS already low at reset release is not taken as a fresh fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_seen <= 1'b0;
            armed    <= 1'b0;
        end else begin
            rst_seen <= 1'b1;
            if (rst_seen && cs_sync[0]) armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            first_byte  <= 1'b1;
            byte_done   <= 1'b0;
            rx_shift    <= 7'd0;
            tx_shift    <= 8'd0;
            rx_data     <= 8'd0;
            rx_valid    <= 1'b0;
            rx_first    <= 1'b0;
            tx_req      <= 1'b0;
            frame_abort <= 1'b0;
            miso_out    <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            first_byte  <= first_nxt;
            byte_done   <= byte_done_nxt;
            rx_shift    <= rx_shift_nxt;
            tx_shift    <= tx_shift_nxt;
            rx_data     <= rx_data_nxt;
            rx_valid    <= rx_valid_nxt;
            rx_first    <= rx_first_nxt;
            tx_req      <= tx_req_nxt;
            frame_abort <= abort_nxt;
            miso_out    <= miso_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        first_nxt     = first_byte;
        byte_done_nxt = byte_done;
        rx_shift_nxt  = rx_shift;
        tx_shift_nxt  = tx_shift;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = 1'b0;
        rx_first_nxt  = 1'b0;
        tx_req_nxt    = 1'b0;
        abort_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall && armed) begin
                    state_nxt     = ACTIVE;
                    bit_cnt_nxt   = 3'd0;
                    first_nxt     = 1'b1;
                    byte_done_nxt = 1'b0;
                    tx_shift_nxt  = tx_data;
                    tx_req_nxt    = 1'b1;
                end
            end
            ACTIVE: begin
                // CS rise takes priority over any SCK edge seen on the same cycle.
                if (cs_rise) begin
                    state_nxt    = IDLE;
                    abort_nxt    = (bit_cnt != 3'd0);
                    bit_cnt_nxt  = 3'd0;
                    rx_shift_nxt = 7'd0;
                end else begin
                    if (sck_rise) begin
                        rx_shift_nxt = {rx_shift[5:0], mosi_s};
                        bit_cnt_nxt  = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_nxt   = {rx_shift, mosi_s};
                            rx_valid_nxt  = 1'b1;
                            rx_first_nxt  = first_byte;
                            first_nxt     = 1'b0;
                            byte_done_nxt = 1'b1;
                        end
                    end
                    if (sck_fall) begin
                        if (bit_cnt == 3'd0 && byte_done) begin
                            tx_shift_nxt = tx_data;
                            tx_req_nxt   = 1'b1;
                        end else begin
                            tx_shift_nxt = {tx_shift[6:0], 1'b0};
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        miso_nxt = (state_nxt == ACTIVE) ? tx_shift_nxt[7] : 1'b0;
    end

endmodule

// File: tb/tb_tt_um_emern_spi_phy.sv
// Directed bench for the SPI PHY: drives the pins of a default-depth and a
// three-stage instance in lockstep and checks events, data and latency.
module tb_tt_um_emern_spi_phy;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_in = 1'b1;
    logic       sck_in = 1'b0;
    logic       mosi_in = 1'b0;
    logic [7:0] tx_data = 8'h00;

    logic       miso_out, tx_req, rx_valid, rx_first, frame_active, frame_abort;
    logic [7:0] rx_data;
    logic       miso_out_3, tx_req_3, rx_valid_3, rx_first_3, frame_active_3, frame_abort_3;
    logic [7:0] rx_data_3;

    tt_um_emern_spi_phy dut (
        .clk(clk), .rst_n(rst_n), .cs_in(cs_in), .sck_in(sck_in), .mosi_in(mosi_in),
        .miso_out(miso_out), .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_first(rx_first), .frame_active(frame_active),
        .frame_abort(frame_abort)
    );

    tt_um_emern_spi_phy #(.SYNC_STAGES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cs_in(cs_in), .sck_in(sck_in), .mosi_in(mosi_in),
        .miso_out(miso_out_3), .tx_data(tx_data), .tx_req(tx_req_3), .rx_data(rx_data_3),
        .rx_valid(rx_valid_3), .rx_first(rx_first_3), .frame_active(frame_active_3),
        .frame_abort(frame_abort_3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Event monitor: counts pulses and flags protocol violations.
    int rx_cnt = 0, tx_cnt = 0, ab_cnt = 0;
    int rx_cnt3 = 0, tx_cnt3 = 0, ab_cnt3 = 0;
    int bad = 0;
    logic [7:0] last_rx = 8'h00;
    logic       last_first = 1'b0;
    logic       rv_p = 1'b0, tr_p = 1'b0, ab_p = 1'b0;
    logic       rv_p3 = 1'b0, tr_p3 = 1'b0, ab_p3 = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt     <= rx_cnt + 1;
            last_rx    <= rx_data;
            last_first <= rx_first;
        end
        if (tx_req) tx_cnt <= tx_cnt + 1;
        if (frame_abort) ab_cnt <= ab_cnt + 1;
        if (rx_valid_3) rx_cnt3 <= rx_cnt3 + 1;
        if (tx_req_3) tx_cnt3 <= tx_cnt3 + 1;
        if (frame_abort_3) ab_cnt3 <= ab_cnt3 + 1;
        bad <= bad
             + (((rx_valid && rv_p) || (tx_req && tr_p) || (frame_abort && ab_p)) ? 1 : 0)
             + (((!rx_valid && rx_first) || (!frame_active && miso_out)) ? 1 : 0)
             + (((rx_valid_3 && rv_p3) || (tx_req_3 && tr_p3) || (frame_abort_3 && ab_p3)) ? 1 : 0)
             + (((!rx_valid_3 && rx_first_3) || (!frame_active_3 && miso_out_3)) ? 1 : 0);
        rv_p  <= rx_valid;
        tr_p  <= tx_req;
        ab_p  <= frame_abort;
        rv_p3 <= rx_valid_3;
        tr_p3 <= tx_req_3;
        ab_p3 <= frame_abort_3;
    end

    logic [7:0] mi = 8'h00, mi3 = 8'h00;
    int lat = 0, lat3 = 0;

    // Shifts n bits of mo (MSB first) with a 16-clk SCK period; on the eighth
    // bit it measures clk cycles from the SCK pin rise to rx_valid.
    task automatic spi_bits(input logic [7:0] mo, input int n, input bit last, input bit exp_rx);
        for (int i = 7; i >= 8 - n; i--) begin
            mosi_in = mo[i];
            #60;
            mi[i]  = miso_out;
            mi3[i] = miso_out_3;
            sck_in = 1'b1;
            if (i == 0) begin
                lat  = 0;
                lat3 = 0;
                for (int k = 1; k <= 6; k++) begin
                    @(posedge clk);
                    #1;
                    if (rx_valid && lat == 0) lat = k;
                    if (rx_valid_3 && lat3 == 0) lat3 = k;
                end
                @(negedge clk);
                #20;
                if (exp_rx) begin
                    chk("latency_s2", lat, 3);
                    chk("latency_s3", lat3, 4);
                end else begin
                    chk("no_rx_s2", lat, 0);
                    chk("no_rx_s3", lat3, 0);
                end
            end else begin
                #80;
            end
            sck_in = 1'b0;
            if (last && i == 0) cs_in = 1'b1;
            #20;
        end
    endtask

    int b_rx, b_tx, b_ab, b_rx3, b_tx3, b_ab3;
    logic [7:0] m1, m2, m3;

    task automatic snap();
        b_rx  = rx_cnt;
        b_tx  = tx_cnt;
        b_ab  = ab_cnt;
        b_rx3 = rx_cnt3;
        b_tx3 = tx_cnt3;
        b_ab3 = ab_cnt3;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #20;
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_pulses", {rx_valid, tx_req, frame_abort, rx_first}, 4'b0000);
        chk("rst_miso", miso_out, 1'b0);
        chk("rst_active", {frame_active, frame_active_3}, 2'b00);
        rst_n = 1'b1;
        #100;

        // Single byte
        tx_data = 8'hA5;
        snap();
        cs_in = 1'b0;
        #160;
        chk("t1_active", frame_active, 1'b1);
        chk("t1_txreq_cs", tx_cnt - b_tx, 1);
        spi_bits(8'h3C, 8, 1'b1, 1'b1);
        #160;
        chk("t1_miso", mi, 8'hA5);
        chk("t1_miso_s3", mi3, 8'hA5);
        chk("t1_rx", last_rx, 8'h3C);
        chk("t1_rx_pin", rx_data, 8'h3C);
        chk("t1_first", last_first, 1'b1);
        chk("t1_rxcnt", rx_cnt - b_rx, 1);
        chk("t1_rxcnt_s3", rx_cnt3 - b_rx3, 1);
        chk("t1_txcnt", tx_cnt - b_tx, 1);
        chk("t1_abort", ab_cnt - b_ab, 0);
        chk("t1_idle", frame_active, 1'b0);

        // Three-byte frame with tx_data changed after the first load
        tx_data = 8'h3C;
        snap();
        cs_in = 1'b0;
        #160;
        tx_data = 8'h5A;
        spi_bits(8'h01, 8, 1'b0, 1'b1);
        m1 = mi;
        chk("t2_b1", {last_first, last_rx}, {1'b1, 8'h01});
        spi_bits(8'h80, 8, 1'b0, 1'b1);
        m2 = mi;
        chk("t2_b2", {last_first, last_rx}, {1'b0, 8'h80});
        spi_bits(8'hFF, 8, 1'b1, 1'b1);
        m3 = mi;
        chk("t2_b3", {last_first, last_rx}, {1'b0, 8'hFF});
        #160;
        chk("t2_miso1", m1, 8'h3C);
        chk("t2_miso2", m2, 8'h5A);
        chk("t2_miso3", m3, 8'h5A);
        chk("t2_miso3_s3", mi3, 8'h5A);
        chk("t2_rxcnt", rx_cnt - b_rx, 3);
        chk("t2_txcnt", tx_cnt - b_tx, 3);
        chk("t2_txcnt_s3", tx_cnt3 - b_tx3, 3);
        chk("t2_abort", ab_cnt - b_ab, 0);

        // Abort after five bits, then a clean frame
        snap();
        cs_in = 1'b0;
        #160;
        spi_bits(8'hE7, 5, 1'b0, 1'b0);
        #60;
        cs_in = 1'b1;
        #160;
        chk("t3_abort", ab_cnt - b_ab, 1);
        chk("t3_abort_s3", ab_cnt3 - b_ab3, 1);
        chk("t3_norx", rx_cnt - b_rx, 0);
        chk("t3_rx_hold", rx_data, 8'hFF);
        chk("t3_idle", frame_active, 1'b0);
        snap();
        cs_in = 1'b0;
        #160;
        spi_bits(8'hC3, 8, 1'b1, 1'b1);
        #160;
        chk("t3_rx", {last_first, last_rx}, {1'b1, 8'hC3});
        chk("t3_rxcnt", rx_cnt - b_rx, 1);
        chk("t3_noabort", ab_cnt - b_ab, 0);

        // SCK activity while CS is high
        snap();
        spi_bits(8'hFF, 8, 1'b0, 1'b0);
        #160;
        chk("t4_events", {rx_cnt - b_rx, tx_cnt - b_tx, ab_cnt - b_ab}, 0);
        chk("t4_miso", {mi, mi3}, 16'h0000);
        chk("t4_idle", frame_active, 1'b0);

        // Reset mid-frame, released with CS still low
        tx_data = 8'hA5;
        snap();
        cs_in = 1'b0;
        #160;
        spi_bits(8'hF0, 4, 1'b0, 1'b0);
        #20;
        rst_n = 1'b0;
        #20;
        chk("t5_rst_rx_data", rx_data, 8'h00);
        chk("t5_rst_miso", miso_out, 1'b0);
        rst_n = 1'b1;
        #160;
        chk("t5_wait", {frame_active, frame_active_3}, 2'b00);
        spi_bits(8'h55, 8, 1'b0, 1'b0);
        #60;
        chk("t5_miso", mi, 8'h00);
        chk("t5_rx_data", rx_data, 8'h00);
        chk("t5_norx", rx_cnt - b_rx, 0);
        chk("t5_noabort", (ab_cnt - b_ab) + (ab_cnt3 - b_ab3), 0);
        chk("t5_txcnt", tx_cnt - b_tx, 1);
        cs_in = 1'b1;
        #160;
        snap();
        cs_in = 1'b0;
        #160;
        chk("t5_restart", frame_active, 1'b1);
        chk("t5_restart_tx", tx_cnt - b_tx, 1);
        spi_bits(8'h96, 8, 1'b1, 1'b1);
        #160;
        chk("t5_rx", {last_first, last_rx}, {1'b1, 8'h96});
        chk("t5_miso_tx", {mi, mi3}, 16'hA5A5);
        chk("t5_rxcnt", rx_cnt - b_rx, 1);

        chk("protocol_violations", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
